// File: rtl/gost89_pkg.sv
// Shared constants and types for the GOST 28147-89 ECB arbiter slice.
package gost89_pkg;

    localparam int GOST89_BLOCK_W = 64;
    localparam int GOST89_KEY_W   = 256;
    localparam int GOST89_SBOX_W  = 512;
    localparam int GOST89_ROUNDS  = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_LOAD = 2'd1,
        ARB_RUN  = 2'd2,
        ARB_RESP = 2'd3
    } gost89_arb_state_t;

endpackage

// File: rtl/gost89_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after ptr_i,
// wrapping around. Produces a one-hot grant, its index and an any flag.
module gost89_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Scan N_REQ positions starting at ptr_i; the first hit wins.
    always_comb begin
        int pos;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(ptr_i) + k) % N_REQ;
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/gost89_ecb_arbiter.sv
// Round-robin scheduler sharing one GOST 28147-89 ECB encrypt core among
// N_REQ requesters. One block in flight at a time; the result is returned
// tagged with the submitting requester's index.
// Build option: GOST89_ARB_KEYSEL_EN selects a per-requester key port
// (req_key_i) instead of the single shared key port (key_i).
//
// state | meaning
// IDLE  | search requests from rr_ptr, accept one, latch block/key/id
// LOAD  | one-cycle load_data pulse to the core
// RUN   | wait for core busy to drop (first cycle always waits)
// RESP  | hold result until resp_ready, then advance rr_ptr
module gost89_ecb_arbiter
    import gost89_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req_valid_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic [GOST89_BLOCK_W*N_REQ-1:0]  req_data_i,
`ifdef GOST89_ARB_KEYSEL_EN
    input  logic [GOST89_KEY_W*N_REQ-1:0]    req_key_i,
`else
    input  logic [GOST89_KEY_W-1:0]          key_i,
`endif
    output logic                             resp_valid_o,
    input  logic                             resp_ready_i,
    output logic [GOST89_BLOCK_W-1:0]        resp_data_o,
    output logic [ID_W-1:0]                  resp_id_o,
    output logic                             core_load_o,
    output logic                             core_reset_o,
    output logic [GOST89_BLOCK_W-1:0]        core_in_o,
    output logic [GOST89_KEY_W-1:0]          core_key_o,
    input  logic [GOST89_BLOCK_W-1:0]        core_out_i,
    input  logic                             core_busy_i
);

    gost89_arb_state_t           state_q, state_d;
    logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [GOST89_BLOCK_W-1:0]   core_in_q;
    logic [GOST89_KEY_W-1:0]     core_key_q;
    logic [GOST89_BLOCK_W-1:0]   resp_data_q;
    logic [ID_W-1:0]             resp_id_q;
    logic                        resp_valid_q;
    logic                        run_first_q;

    logic [N_REQ-1:0]            arb_gnt;
    logic [ID_W-1:0]             arb_idx;
    logic                        arb_any;
    logic [GOST89_BLOCK_W-1:0]   sel_data;
    logic [GOST89_KEY_W-1:0]     sel_key;
    logic                        accept;
    logic                        core_done;
    logic                        resp_hs;

    gost89_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign sel_data = req_data_i[int'(arb_idx)*GOST89_BLOCK_W +: GOST89_BLOCK_W];
`ifdef GOST89_ARB_KEYSEL_EN
    assign sel_key  = req_key_i[int'(arb_idx)*GOST89_KEY_W +: GOST89_KEY_W];
`else
    assign sel_key  = key_i;
`endif

    assign accept    = (state_q == ARB_IDLE) && arb_any;
    assign core_done = (state_q == ARB_RUN) && !run_first_q && !core_busy_i;
    assign resp_hs   = (state_q == ARB_RESP) && resp_ready_i;
    assign rr_ptr_d  = (resp_id_q == ID_W'(N_REQ - 1)) ? '0 : resp_id_q + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (arb_any)      state_d = ARB_LOAD;
            ARB_LOAD:                   state_d = ARB_RUN;
            ARB_RUN:  if (core_done)    state_d = ARB_RESP;
            ARB_RESP: if (resp_ready_i) state_d = ARB_IDLE;
            default:                    state_d = ARB_IDLE;
        endcase
    end

    // Moore/Mealy outputs; both pulses are suppressed while reset is high so
    // nothing is accepted or loaded into a core that is itself being reset.
    always_comb begin
        req_ready_o = '0;
        core_load_o = 1'b0;
        case (state_q)
            ARB_IDLE: if (!reset) req_ready_o = arb_gnt;
            ARB_LOAD: core_load_o = !reset;
            default: ;
        endcase
    end

    // Datapath: grant latches, result capture, pointer advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            core_in_q    <= '0;
            core_key_q   <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            run_first_q  <= 1'b0;
        end else begin
            run_first_q <= (state_q == ARB_LOAD);
            if (accept) begin
                core_in_q  <= sel_data;
                core_key_q <= sel_key;
                resp_id_q  <= arb_idx;
            end
            if (core_done) begin
                resp_data_q  <= core_out_i;
                resp_valid_q <= 1'b1;
            end
            if (resp_hs) begin
                resp_valid_q <= 1'b0;
                rr_ptr_q     <= rr_ptr_d;
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_id_o    = resp_id_q;
    assign core_in_o    = core_in_q;
    assign core_key_o   = core_key_q;
    assign core_reset_o = reset;

endmodule
